// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch controller.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

    localparam int          ROM_ADDR_W = 8;
    localparam int          ROM_DATA_W = 16;
    localparam logic [15:0] HALT_WORD  = 16'hFFFF;
endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready holding register carrying an instruction and its fetch address.
module fetch_out_reg #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [DATA_W-1:0] code,
    input  logic [ADDR_W-1:0] pc,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    // Flush wins over load; load never coincides with flush at the top level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (load && !flush) begin
                instr    <= code;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the combinational program ROM: fetches one word per cycle
// into a valid/ready output stage, follows start/redirect, and stops after the halt word.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = ROM_ADDR_W,
    parameter int                DATA_W      = ROM_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(HALT_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_pc_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] rom_pc_o,
    input  logic [DATA_W-1:0] rom_code_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              busy_o,
    output logic              halted_o
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              busy;
    logic              halted;
    logic              capture;
    logic              flush;

    // Redirect takes priority over capture; a stalled output blocks capture.
    assign capture = (state == RUN) && !redirect_i && (!instr_valid_o || instr_ready_i);
    // Start out of IDLE/HALT drops any held halt word; redirect drops the wrong-path word.
    assign flush   = ((state != RUN) && start_i) || ((state == RUN) && redirect_i);

    assign rom_pc_o = fetch_pc;
    assign busy_o   = busy;
    assign halted_o = halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start_i) begin
                        state    <= RUN;
                        fetch_pc <= start_pc_i;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                RUN: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_pc_i;
                    end else if (capture) begin
                        fetch_pc <= fetch_pc + ADDR_W'(1);
                        if (rom_code_i == HALT_OPCODE) begin
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    fetch_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (capture),
        .flush    (flush),
        .ready    (instr_ready_i),
        .code     (rom_code_i),
        .pc       (fetch_pc),
        .valid    (instr_valid_o),
        .instr    (instr_o),
        .instr_pc (instr_pc_o)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural combinational ROM image.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_pc;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  rom_pc;
    logic [15:0] rom_code;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        busy;
    logic        halted;

    logic [15:0] rom [0:255];
    logic [15:0] exp_stream [0:10];

    int n_cmp;
    int n_err;

    assign rom_code = rom[rom_pc];

    fetch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .start_pc_i    (start_pc),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .rom_pc_o      (rom_pc),
        .rom_code_i    (rom_code),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .busy_o        (busy),
        .halted_o      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] code, input logic [7:0] pc);
        chk_eq({tag, " valid"}, 32'(instr_valid), 32'd1);
        chk_eq({tag, " instr"}, 32'(instr), 32'(code));
        chk_eq({tag, " pc"}, 32'(instr_pc), 32'(pc));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        exp_stream = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                       16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hFFFF};
        for (int i = 0; i < 11; i++) rom[i] = exp_stream[i];
        rom[8'hFE] = 16'h1234;
        rom[8'hFF] = 16'h5678;

        rst_n = 1'b0; start = 1'b0; start_pc = 8'h00;
        redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
        #2;
        chk_eq("rst rom_pc", 32'(rom_pc), 32'h00);
        chk_eq("rst valid", 32'(instr_valid), 32'd0);
        chk_eq("rst instr", 32'(instr), 32'h0);
        chk_eq("rst instr_pc", 32'(instr_pc), 32'h0);
        chk_eq("rst busy", 32'(busy), 32'd0);
        chk_eq("rst halted", 32'(halted), 32'd0);
        step();
        rst_n = 1'b1;

        // Full stream from 0 through the halt word
        start = 1'b1; start_pc = 8'h00; instr_ready = 1'b1;
        step();
        start = 1'b0;
        chk_eq("run busy", 32'(busy), 32'd1);
        chk_eq("run first valid", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 11; k++) begin
            step();
            chk_out($sformatf("stream%0d", k), exp_stream[k], 8'(k));
        end
        chk_eq("halt halted", 32'(halted), 32'd1);
        chk_eq("halt busy", 32'(busy), 32'd0);
        chk_eq("halt rom_pc", 32'(rom_pc), 32'd11);
        step();
        chk_eq("halt retire", 32'(instr_valid), 32'd0);
        step();
        chk_eq("halt idle valid", 32'(instr_valid), 32'd0);
        chk_eq("halt idle rom_pc", 32'(rom_pc), 32'd11);
        chk_eq("halt idle halted", 32'(halted), 32'd1);

        // Stall with ready low, then redirect while 2222 is pending
        instr_ready = 1'b0; start = 1'b1; start_pc = 8'h00;
        step();
        start = 1'b0;
        chk_eq("restart halted", 32'(halted), 32'd0);
        step();
        chk_out("stall cap", 16'h0000, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("stall%0d", k), 16'h0000, 8'h00);
            chk_eq($sformatf("stall%0d rom_pc", k), 32'(rom_pc), 32'h01);
        end
        instr_ready = 1'b1;
        step();
        chk_out("release", 16'h1111, 8'h01);
        step();
        chk_out("pre redirect", 16'h2222, 8'h02);
        redirect = 1'b1; redirect_pc = 8'h08;
        step();
        redirect = 1'b0;
        chk_eq("redirect valid", 32'(instr_valid), 32'd0);
        chk_eq("redirect rom_pc", 32'(rom_pc), 32'h08);
        step();
        chk_out("redir 8", 16'h8888, 8'h08);
        step();
        chk_out("redir 9", 16'h9999, 8'h09);
        step();
        chk_out("redir halt", 16'hFFFF, 8'h0A);
        chk_eq("redir halted", 32'(halted), 32'd1);
        step();
        chk_eq("redir retire", 32'(instr_valid), 32'd0);

        // PC wrap from FE, with a start pulse ignored while running
        start = 1'b1; start_pc = 8'hFE;
        step();
        start = 1'b0;
        chk_eq("wrap rom_pc", 32'(rom_pc), 32'hFE);
        step();
        chk_out("wrap FE", 16'h1234, 8'hFE);
        step();
        chk_out("wrap FF", 16'h5678, 8'hFF);
        chk_eq("wrap rom_pc0", 32'(rom_pc), 32'h00);
        step();
        chk_out("wrap 00", 16'h0000, 8'h00);
        start = 1'b1; start_pc = 8'h05;
        step();
        start = 1'b0;
        chk_out("start ignored", 16'h1111, 8'h01);
        chk_eq("start ignored busy", 32'(busy), 32'd1);
        step();
        chk_out("wrap cont", 16'h2222, 8'h02);

        // Asynchronous reset mid-stream, then redirect ignored in IDLE
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("async valid", 32'(instr_valid), 32'd0);
        chk_eq("async busy", 32'(busy), 32'd0);
        chk_eq("async halted", 32'(halted), 32'd0);
        chk_eq("async rom_pc", 32'(rom_pc), 32'h00);
        chk_eq("async instr", 32'(instr), 32'h0);
        #1;
        rst_n = 1'b1;
        redirect = 1'b1; redirect_pc = 8'h05;
        step();
        redirect = 1'b0;
        chk_eq("idle busy", 32'(busy), 32'd0);
        chk_eq("idle redirect rom_pc", 32'(rom_pc), 32'h00);
        step();
        chk_eq("idle valid", 32'(instr_valid), 32'd0);
        start = 1'b1; start_pc = 8'h03;
        step();
        start = 1'b0;
        step();
        chk_out("after reset", 16'h3333, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the 256 x 16 combinational program ROM (program_rom) by owning the program counter. It presents one instruction per cycle to the downstream decoder over a valid/ready handshake, and follows start and branch-redirect commands. It stops after fetching a designated halt word.
The ROM stays a separate instance. This block drives its address and samples its data in the same cycle.

Parameters:
ADDR_W, 8, ROM address / PC width
DATA_W, 16, instruction width
RESET_PC, 0, PC value loaded at reset
HALT_OPCODE, 16'hFFFF, instruction word that ends fetching

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start_i  in  1  begin fetching at start_pc_i (honoured in IDLE or HALT)
start_pc_i  in  ADDR_W  start address
redirect_i  in  1  branch/jump redirect (honoured in RUN only)
redirect_pc_i  in  ADDR_W  redirect target
rom_pc_o  out  ADDR_W  address to program_rom.pc
rom_code_i  in  DATA_W  data from program_rom.code (combinational, same cycle)
instr_valid_o  out  1  output instruction valid
instr_ready_i  in  1  decoder accepts instruction
instr_o  out  DATA_W  registered instruction word
instr_pc_o  out  ADDR_W  address the instruction was fetched from
busy_o  out  1  high while state is RUN
halted_o  out  1  high while state is HALT

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE, fetch_pc=RESET_PC, so rom_pc_o=RESET_PC.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0, busy_o=0, halted_o=0.
- rom_pc_o is always equal to the fetch_pc register.
- States: IDLE, RUN, HALT.
  - IDLE -start_i-> RUN.
  - RUN -capture of HALT_OPCODE-> HALT.
  - HALT -start_i-> RUN.
  - No other transitions.
- start_i (IDLE/HALT):
  - fetch_pc<=start_pc_i, instr_valid_o<=0 (flushes a pending halt word), state<=RUN.
  - Ignored in RUN.
- Capture condition: state==RUN && !redirect_i && (!instr_valid_o || instr_ready_i).
- On capture:
  - instr_o<=rom_code_i, instr_pc_o<=fetch_pc, instr_valid_o<=1.
  - fetch_pc<=fetch_pc+1, modulo 2^ADDR_W (255 wraps to 0).
- Handshake retire: instr_valid_o && instr_ready_i with no new capture -> instr_valid_o<=0.
- Stall: instr_valid_o && !instr_ready_i. instr_o, instr_pc_o, instr_valid_o and fetch_pc all hold.
- Throughput: one instruction per cycle while instr_ready_i=1.
- Latency: start_i sampled at edge N -> instr_valid_o=1 after edge N+1, carrying ROM[start_pc_i].
- Halt:
  - Capturing rom_code_i==HALT_OPCODE delivers that word normally, sets state<=HALT and leaves fetch_pc at the halt address+1.
  - No further fetches occur. The held halt word still completes its handshake.
- redirect_i in RUN:
  - Has priority over capture: fetch_pc<=redirect_pc_i, instr_valid_o<=0, no capture that cycle.
  - The instruction at redirect_pc_i is captured on the next edge if RUN continues.
  - Ignored in IDLE/HALT.
- Simultaneous start_i and redirect_i: each is only legal in disjoint states, so the current state decides.
- Wrap-around: the PC wrap has no side effect. Fetching continues at 0.

Decomposition:
- Package fetch_pkg contains:
  - typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t
  - default constants ROM_ADDR_W=8, ROM_DATA_W=16, HALT_WORD=16'hFFFF
- One natural sub-module: fetch_out_reg. It is the one-entry valid/ready holding register, with load/flush inputs and an instruction+pc payload.
- The state machine and PC counter stay in fetch_sequencer.

Test Plan:
- Bench ROM image: ROM[n]=n*16'h1111 for n=0..9, ROM[10]=16'hFFFF.
- Reset then start_i, start_pc_i=0, ready=1 -> valid from second edge. Stream 0000,1111,…,9999,FFFF with instr_pc_o 0..10. Then halted_o=1, busy_o=0, no further valid.
- Ready held 0 for 3 cycles after first capture -> instr_o=16'h0000, instr_pc_o=0 stable and rom_pc_o=1 throughout. Release -> 1111 next.
- Redirect to 8 while instr_o=16'h2222 pending -> valid drops for one cycle, then 8888, 9999, FFFF, then HALT.
- start_pc_i=8'hFE with ROM[FE]=1234, ROM[FF]=5678, ROM[0]=0000 -> sequence 1234,5678,0000 with instr_pc_o FE,FF,00 (wrap).
- rst_n asserted mid-stream while valid=1 -> valid, busy_o, halted_o drop immediately with no clock edge, rom_pc_o=RESET_PC. After release the block stays in IDLE until start_i.
